// File: rtl/servo_ctrl_pkg.sv
// Shared definitions for the servo ramp controller: register map, reset
// defaults, CTRL/STATUS bit positions and the ramp state encoding.
package servo_ctrl_pkg;

  localparam logic [1:0] ADDR_TARGET   = 2'd0;
  localparam logic [1:0] ADDR_STEP     = 2'd1;
  localparam logic [1:0] ADDR_INTERVAL = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam logic [31:0] STEP_RESET     = 32'd1000;
  localparam logic [31:0] INTERVAL_RESET = 32'd50000;

  localparam int CTRL_ABORT_BIT  = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  // STEP and INTERVAL of zero would stall the ramp, so zero is promoted to one
  function automatic logic [31:0] at_least_one(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/servo_ramp_tick.sv
// Loadable down-counter that paces the ramp. A load starts a fresh period,
// and while enabled it emits a one-cycle tick when the count reaches 1, then
// reloads from the period input seen on that same cycle.
module servo_ramp_tick
  import servo_ctrl_pkg::*;
(
  input  logic        clock_clk,
  input  logic        reset_low,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] count;

  // Treating a count of 0 as expired keeps a corrupted count from wrapping
  assign tick = enable && (count <= 32'd1);

  // Load on a new ramp, reload on every tick, otherwise count down while enabled
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      count <= INTERVAL_RESET;
    end else if (load || tick) begin
      count <= period;
    end else if (enable) begin
      count <= count - 32'd1;
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited servo position controller with an Avalon-MM register slave.
// Software writes a target; pos_out walks toward it by STEP every INTERVAL
// clocks. Optional done interrupt is enabled by defining SERVO_RAMP_IRQ_EN.
module servo_ramp_ctrl
  import servo_ctrl_pkg::*;
#(
  parameter logic [31:0] POS_MIN   = 32'd50000,
  parameter logic [31:0] POS_MAX   = 32'd100000,
  parameter logic [31:0] RESET_POS = 32'd75000
) (
  input  logic        clock_clk,
  input  logic        reset_low,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] pos_out,
  output logic        busy,
  output logic        done_irq
);

  logic [0:0]  state;
  logic [31:0] pos;
  logic [31:0] target;
  logic [31:0] step;
  logic [31:0] interval;

  logic        wr_en;
  logic        rd_en;
  logic        target_wr;
  logic        step_wr;
  logic        interval_wr;
  logic        ctrl_wr;
  logic        abort;
  logic        ramping;

  logic [31:0] target_eff;
  logic [31:0] step_eff;
  logic [31:0] interval_eff;

  logic [32:0] diff;
  logic        moving_down;
  logic [32:0] abs_diff;
  logic        within_step;
  logic [31:0] pos_next;

  logic        tick;
  logic        step_now;
  logic        finish;
  logic        done_pending;
  logic [31:0] status_word;

  function automatic logic [31:0] clamp_pos(input logic [31:0] value);
    if (value < POS_MIN) begin
      return POS_MIN;
    end else if (value > POS_MAX) begin
      return POS_MAX;
    end
    return value;
  endfunction

  assign wr_en       = cs && write;
  assign rd_en       = cs && read;
  assign target_wr   = wr_en && (address == ADDR_TARGET);
  assign step_wr     = wr_en && (address == ADDR_STEP);
  assign interval_wr = wr_en && (address == ADDR_INTERVAL);
  assign ctrl_wr     = wr_en && (address == ADDR_CTRL);
  assign abort       = ctrl_wr && writedata[CTRL_ABORT_BIT];
  assign ramping     = (state == ST_RAMP);

  // A write landing on a tick edge is already visible to that tick, so the
  // step always heads for the newest target with the newest step size
  assign target_eff   = target_wr   ? clamp_pos(writedata)    : target;
  assign step_eff     = step_wr     ? at_least_one(writedata) : step;
  assign interval_eff = interval_wr ? at_least_one(writedata) : interval;

  // Signed 33-bit distance to target; the final step snaps exactly onto it
  assign diff        = {1'b0, target_eff} - {1'b0, pos};
  assign moving_down = diff[32];
  assign abs_diff    = moving_down ? (~diff + 33'd1) : diff;
  assign within_step = (abs_diff <= {1'b0, step_eff});

  always_comb begin
    pos_next = pos + step_eff;
    if (within_step) begin
      pos_next = target_eff;
    end else if (moving_down) begin
      pos_next = pos - step_eff;
    end
  end

  servo_ramp_tick u_tick (
    .clock_clk (clock_clk),
    .reset_low (reset_low),
    .load      (target_wr && !ramping),
    .enable    (ramping),
    .period    (interval_eff),
    .tick      (tick)
  );

  assign step_now = ramping && tick && !abort;
  assign finish   = step_now && within_step;

  // Configuration registers follow their write strobes
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      target   <= RESET_POS;
      step     <= STEP_RESET;
      interval <= INTERVAL_RESET;
    end else begin
      target   <= target_eff;
      step     <= step_eff;
      interval <= interval_eff;
    end
  end

  // Ramp state and position: abort beats a tick, a tick moves pos one step
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state <= ST_IDLE;
      pos   <= RESET_POS;
    end else if (ramping && abort) begin
      state <= ST_IDLE;
    end else if (step_now) begin
      pos <= pos_next;
      if (within_step) begin
        state <= ST_IDLE;
      end
    end else if (target_wr) begin
      state <= ST_RAMP;
    end
  end

`ifdef SERVO_RAMP_IRQ_EN
  logic clear_done;
  assign clear_done = ctrl_wr && writedata[CTRL_CLEAR_BIT];

  // Completion flag held until software clears it; completion wins a tie
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      done_pending <= 1'b0;
    end else if (finish) begin
      done_pending <= 1'b1;
    end else if (clear_done) begin
      done_pending <= 1'b0;
    end
  end
`else
  assign done_pending = 1'b0;
  logic unused_finish;
  assign unused_finish = finish;
`endif

  // STATUS word assembled from live busy and done flags
  always_comb begin
    status_word                  = 32'd0;
    status_word[STATUS_BUSY_BIT] = ramping;
    status_word[STATUS_DONE_BIT] = done_pending;
  end

  // Registered read port, one clock of latency
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      readdata <= 32'd0;
    end else if (rd_en) begin
      case (address)
        ADDR_TARGET:   readdata <= pos;
        ADDR_STEP:     readdata <= step;
        ADDR_INTERVAL: readdata <= interval;
        default:       readdata <= status_word;
      endcase
    end
  end

  assign pos_out  = pos;
  assign busy     = ramping;
  assign done_irq = done_pending;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl. A schedule-based model (absolute
// cycle of the next step) predicts outputs every cycle; directed scenarios
// add hand-computed expectations, then a randomized register traffic phase.
module tb_servo_ramp_ctrl;

`ifdef SERVO_RAMP_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clock_clk = 1'b0;
  logic        reset_low = 1'b0;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] pos_out;
  logic        busy;
  logic        done_irq;

  int compared = 0;
  int mismatched = 0;

  longint m_pos, m_target, m_step, m_interval, m_next, cycleNo;
  bit     m_busy, m_dp;
  logic [31:0] m_rdata;

  servo_ramp_ctrl dut (
    .clock_clk (clock_clk),
    .reset_low (reset_low),
    .cs        (cs),
    .write     (write),
    .read      (read),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .pos_out   (pos_out),
    .busy      (busy),
    .done_irq  (done_irq)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, actual, expected, cycleNo);
    end
  endtask

  function automatic bit dpVisible();
    return IRQ_EN && m_dp;
  endfunction

  task automatic modelReset();
    m_pos = 75000; m_target = 75000; m_step = 1000; m_interval = 50000;
    m_busy = 0; m_dp = 0; m_rdata = 32'd0; m_next = 0;
  endtask

  // One clock edge of the register map and ramp rules, using the inputs held there
  task automatic stepModel();
    longint wd, d;
    bit doAbort, doClear;
    cycleNo++;
    wd = longint'(writedata);
    doAbort = 0; doClear = 0;
    if (cs && read) begin
      case (address)
        2'd0: m_rdata = 32'(m_pos);
        2'd1: m_rdata = 32'(m_step);
        2'd2: m_rdata = 32'(m_interval);
        default: m_rdata = {30'd0, dpVisible(), m_busy};
      endcase
    end
    if (cs && write) begin
      case (address)
        2'd0: begin
          m_target = (wd < 50000) ? 50000 : (wd > 100000) ? 100000 : wd;
          if (!m_busy) begin
            m_busy = 1;
            m_next = cycleNo + m_interval;
          end
        end
        2'd1: m_step = (wd == 0) ? 1 : wd;
        2'd2: m_interval = (wd == 0) ? 1 : wd;
        default: begin
          doAbort = writedata[0];
          doClear = writedata[1];
        end
      endcase
    end
    if (doClear) m_dp = 0;
    if (m_busy && doAbort) begin
      m_busy = 0;
    end else if (m_busy && cycleNo == m_next) begin
      d = m_target - m_pos;
      if (d <= m_step && -d <= m_step) begin
        m_pos = m_target;
        m_busy = 0;
        m_dp = 1;
      end else begin
        m_pos = (d < 0) ? m_pos - m_step : m_pos + m_step;
        m_next = cycleNo + m_interval;
      end
    end
  endtask

  // Advance one clock, update the model, then compare every output
  task automatic advanceCycle();
    @(posedge clock_clk);
    #1;
    if (!reset_low) begin
      cycleNo++;
      modelReset();
    end else begin
      stepModel();
    end
    checkOutput("pos_out", pos_out, 32'(m_pos));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("done_irq", 32'(done_irq), 32'(dpVisible()));
    checkOutput("readdata", readdata, m_rdata);
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    cs = c; write = w; read = r; address = a; writedata = d;
    advanceCycle();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic readReg(input logic [1:0] a);
    applyStimulus(1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    idle(1);
    while (busy && n < budget) begin
      idle(1);
      n++;
    end
    if (busy) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    cycleNo = 0;
    modelReset();
    repeat (3) advanceCycle();
    reset_low = 1'b1;

    // Reset state
    checkOutput("reset_pos", pos_out, 32'd75000);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_irq", 32'(done_irq), 32'd0);
    readReg(2'd1);
    checkOutput("reset_step_read", readdata, 32'd1000);
    readReg(2'd2);
    checkOutput("reset_interval_read", readdata, 32'd50000);

    // Basic ramp up 75000 -> 78500
    writeReg(2'd2, 32'd4);
    writeReg(2'd1, 32'd1000);
    writeReg(2'd0, 32'd78500);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      if (k == 4)  checkOutput("ramp_step1", pos_out, 32'd76000);
      if (k == 8)  checkOutput("ramp_step2", pos_out, 32'd77000);
      if (k == 12) checkOutput("ramp_step3", pos_out, 32'd78000);
      if (k == 15) checkOutput("ramp_busy_before_end", 32'(busy), 32'd1);
    end
    checkOutput("ramp_final", pos_out, 32'd78500);
    checkOutput("ramp_busy_end", 32'(busy), 32'd0);
    checkOutput("ramp_irq_end", 32'(done_irq), 32'(IRQ_EN));

    // Clamp low target
    writeReg(2'd3, 32'd2);
    writeReg(2'd0, 32'd20000);
    waitIdle(1000);
    checkOutput("clamp_min_final", pos_out, 32'd50000);

    // Abort six clocks into a ramp 75000 -> 80000
    writeReg(2'd0, 32'd75000);
    waitIdle(1000);
    writeReg(2'd3, 32'd2);
    writeReg(2'd0, 32'd80000);
    idle(5);
    writeReg(2'd3, 32'd1);
    idle(10);
    checkOutput("abort_pos_hold", pos_out, 32'd76000);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_irq", 32'(done_irq), 32'd0);

    // Equal-to-pos style short ramp back to 75000, then retarget mid-ramp
    writeReg(2'd0, 32'd75000);
    idle(4);
    checkOutput("short_ramp_pos", pos_out, 32'd75000);
    checkOutput("short_ramp_busy", 32'(busy), 32'd0);
    writeReg(2'd3, 32'd2);
    writeReg(2'd0, 32'd80000);
    idle(5);
    checkOutput("retarget_first_step", pos_out, 32'd76000);
    writeReg(2'd0, 32'd74000);
    idle(2);
    checkOutput("retarget_step_down1", pos_out, 32'd75000);
    idle(4);
    checkOutput("retarget_final", pos_out, 32'd74000);
    checkOutput("retarget_busy", 32'(busy), 32'd0);

    // Zero STEP and INTERVAL promote to 1
    writeReg(2'd3, 32'd2);
    writeReg(2'd1, 32'd0);
    writeReg(2'd2, 32'd0);
    readReg(2'd1);
    checkOutput("step_zero_read", readdata, 32'd1);
    readReg(2'd2);
    checkOutput("interval_zero_read", readdata, 32'd1);
    writeReg(2'd0, 32'd74010);
    idle(3);
    checkOutput("unit_step_pos3", pos_out, 32'd74003);
    idle(7);
    checkOutput("unit_step_final", pos_out, 32'd74010);

    // Clear racing completion: completion wins
    writeReg(2'd3, 32'd2);
    checkOutput("irq_cleared", 32'(done_irq), 32'd0);
    writeReg(2'd0, 32'd74015);
    idle(4);
    writeReg(2'd3, 32'd2);
    checkOutput("race_pos", pos_out, 32'd74015);
    checkOutput("race_irq_set_wins", 32'(done_irq), 32'(IRQ_EN));
    writeReg(2'd3, 32'd2);
    idle(1);
    checkOutput("race_irq_cleared_after", 32'(done_irq), 32'd0);

    // Randomized register traffic
    writeReg(2'd2, 32'($urandom_range(1, 6)));
    writeReg(2'd1, 32'($urandom_range(200, 3000)));
    for (int i = 0; i < 3000; i++) begin
      int op;
      logic [1:0] a;
      logic [31:0] d;
      op = int'($urandom_range(0, 9));
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(30000, 120000));
        2'd1: d = 32'($urandom_range(0, 3000));
        2'd2: d = 32'($urandom_range(0, 8));
        default: d = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1) << 1);
      endcase
      if (op < 5)       idle(1);
      else if (op < 8)  writeReg(a, d);
      else if (op < 9)  readReg(a);
      else              applyStimulus(1'b1, 1'b1, 1'b1, a, d);
    end
    writeReg(2'd2, 32'd2);
    writeReg(2'd1, 32'd3000);
    waitIdle(2000);

    // Asynchronous reset in the middle of a ramp
    writeReg(2'd2, 32'd3);
    writeReg(2'd0, 32'd90000);
    idle(7);
    #2 reset_low = 1'b0;
    #1;
    checkOutput("async_reset_pos", pos_out, 32'd75000);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_irq", 32'(done_irq), 32'd0);
    checkOutput("async_reset_readdata", readdata, 32'd0);
    advanceCycle();
    advanceCycle();
    reset_low = 1'b1;
    idle(1);
    readReg(2'd1);
    checkOutput("post_reset_step", readdata, 32'd1000);
    readReg(2'd2);
    checkOutput("post_reset_interval", readdata, 32'd50000);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
